// File: rtl/mips_pkg.sv
// Constants shared by the multicycle MIPS datapath: register file geometry,
// the special register indices and the stack pointer reset value.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int SP_RESET   = 227;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  // $0 is hardwired: writes to it vanish and reads of it return zero.
  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] idx);
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Register file port bundle: write-back, two read ports and the A/B operand
// registers, with the control side as master and the register bank as slave.
interface reg_bank_if #(parameter int DATA_W = 32);

  logic              reg_write;
  logic [4:0]        read_reg1;
  logic [4:0]        read_reg2;
  logic [4:0]        write_reg;
  logic [DATA_W-1:0] write_data;
  logic              a_load;
  logic              b_load;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;

  modport master (
    output reg_write, read_reg1, read_reg2, write_reg, write_data, a_load, b_load,
    input  read_data1, read_data2, a_out, b_out
  );

  modport slave (
    input  reg_write, read_reg1, read_reg2, write_reg, write_data, a_load, b_load,
    output read_data1, read_data2, a_out, b_out
  );

endinterface

// File: rtl/reg32_load.sv
// Load-enabled datapath register with asynchronous active-low clear; used for
// the A/B operand latches and for PC, IR, MDR and ALUOut.
module reg32_load #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// Architectural register file of the multicycle MIPS datapath: 32 entries,
// two combinational read ports, one write port, plus the A/B operand registers.
module reg_bank #(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int SP_RESET = mips_pkg::SP_RESET
) (
  input logic       clk,
  input logic       reset,
  reg_bank_if.slave bus
);

  import mips_pkg::*;

  logic [DATA_W-1:0] regs [32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      regs[REG_SP] <= DATA_W'(SP_RESET);
    end else if (bus.reg_write && !is_zero_reg(bus.write_reg)) begin
      regs[bus.write_reg] <= bus.write_data;
    end
  end

  // No write-to-read bypass: a same-edge write is seen only after the edge,
  // so A/B capture the pre-write contents.
  assign bus.read_data1 = is_zero_reg(bus.read_reg1) ? '0 : regs[bus.read_reg1];
  assign bus.read_data2 = is_zero_reg(bus.read_reg2) ? '0 : regs[bus.read_reg2];

  reg32_load #(.DATA_W(DATA_W)) u_a_reg (
    .clk   (clk),
    .reset (reset),
    .load  (bus.a_load),
    .d     (bus.read_data1),
    .q     (bus.a_out)
  );

  reg32_load #(.DATA_W(DATA_W)) u_b_reg (
    .clk   (clk),
    .reset (reset),
    .load  (bus.b_load),
    .d     (bus.read_data2),
    .q     (bus.b_out)
  );

endmodule
